polygon_scheduler: RTL and testbench
====================================

POLYGON_SCHEDULER -- requirements
Module: polygon_scheduler

Interface
REQ-001 SHALL have parameter NUM_POLY, default 4: number of polygon slots; must be a power of two, at least 2.
REQ-002 SHALL have parameter H_ACTIVE, default 640: pixel columns per frame.
REQ-003 SHALL have parameter V_ACTIVE, default 480: pixel rows per frame.
REQ-004 SHALL have port clk  in  1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  in  1: write the polygon slot selected by wr_idx.
REQ-007 SHALL have port wr_idx  in  log2(NUM_POLY): target slot of the write.
REQ-008 SHALL have port wr_valid  in  1: slot-valid bit to store.
REQ-009 SHALL have ports wr_depth  in  9, wr_color  in  18, wr_column  in  18, wr_row  in  18: the polygon record to store.
REQ-010 SHALL have port frame_start  in  1: single-cycle pulse that begins a frame scan.
REQ-011 SHALL have ports busy  out  1 and frame_done  out  1: scan in progress; one-cycle pulse at frame end.
REQ-012 SHALL have ports pixel_clr, cmp_en, pixel_done  out  1 each: pixel-core clear strobe, compare enable, and pixel result valid.
REQ-013 SHALL have ports pixel_row  out  9 and pixel_col  out  10: current pixel coordinates.
REQ-014 SHALL have ports polygon_depth  out  9, polygon_color  out  18, polygon_column  out  18, polygon_row  out  18: the presented polygon record.

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR, COMPARE and EMIT; all outputs SHALL be registered.
REQ-016 IDLE: SHALL accept writes; on frame_start SHALL go to CLEAR with row=0, col=0.
REQ-017 CLEAR: SHALL assert pixel_clr for exactly one cycle, set poly_idx=0, then go to COMPARE.
REQ-018 COMPARE: SHALL present slot poly_idx on the polygon_* outputs with cmp_en=1 for NUM_POLY consecutive cycles in index order 0..NUM_POLY-1, then go to EMIT.
REQ-019 EMIT: SHALL assert pixel_done for one cycle, in which the pixel core's pixel_out holds the result for (pixel_row, pixel_col).
REQ-020 EMIT: col SHALL increment; at col=H_ACTIVE-1 it SHALL wrap to 0 and row SHALL increment; after the pixel (V_ACTIVE-1, H_ACTIVE-1) SHALL pulse frame_done and return to IDLE, otherwise SHALL go to CLEAR.
REQ-021 Per-pixel period SHALL be exactly NUM_POLY+2 cycles, with no idle cycles between pixels.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 wr_en while busy=1 SHALL be ignored, so slot contents stay stable for the whole frame.
REQ-024 frame_start while busy=1 SHALL be ignored.
REQ-025 wr_en and frame_start in the same IDLE cycle: the write SHALL commit, and the frame SHALL use the new data.
REQ-026 Outside COMPARE, the polygon_* outputs SHALL be 0 and cmp_en SHALL be 0.

Reset
REQ-027 rst SHALL force IDLE, row=col=0, poly_idx=0, all outputs 0, and every slot cleared (data 0, valid 0).
REQ-028 rst during a scan SHALL abandon the frame without a frame_done pulse; the next frame SHALL start from (0,0).

Configuration
REQ-029 With POLY_SKIP_INVALID_EN defined, a COMPARE cycle for a slot with valid=0 SHALL hold cmp_en=0 and polygon_*=0; cycle count is unchanged.
REQ-030 Without POLY_SKIP_INVALID_EN, no valid bits SHALL be stored, wr_valid SHALL be ignored, and every slot SHALL be presented with cmp_en=1.

Structure
REQ-031 Package pixel_pkg SHALL hold the field widths (depth 9, color 18, column 18, row 18, row 9, col 10), the packed polygon record typedef, and the FSM state enum.
REQ-032 Slot storage SHALL be the sub-module polygon_regfile (one synchronous write port, one combinational read port indexed by poly_idx, synchronous clear on rst).

Verification (H_ACTIVE=4, V_ACTIVE=2, NUM_POLY=4 unless stated)
REQ-033 Write slots 0..3 with depth 1..4, then pulse frame_start -> pixel_clr at cycle 1; cmp_en during cycles 2-5 with depth 1,2,3,4; pixel_done at cycle 6; 8 pixels; frame_done at cycle 48; busy=0 in cycle 49.
REQ-034 Scan column wrap -> pixel_done sequence (row,col) = (0,0),(0,1),(0,2),(0,3),(1,0)...(1,3); after frame_done, row=col=0.
REQ-035 Pulse wr_en to slot 2 with depth 0x1FF during the 3rd pixel -> the write is ignored, depth of slot 2 is unchanged for the rest of the frame, and frame_start mid-scan has no effect.
REQ-036 Assert rst at cycle 20 of a frame -> all outputs 0 next cycle, no frame_done, all slots read 0, and a new frame_start begins at (0,0).
REQ-037 With POLY_SKIP_INVALID_EN defined, mark only slot 1 valid -> per pixel, cmp_en=1 in only the 2nd COMPARE cycle; the pixel period is still 6 cycles.
REQ-038 Drive wr_en to slot 0 (color 0x3FFFF) and frame_start in the same cycle -> the first COMPARE cycle presents color 0x3FFFF.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared widths, polygon record and scan FSM state for the polygon scheduler.
// Optional feature macro: POLY_SKIP_INVALID_EN (see polygon_regfile / polygon_scheduler).
package pixel_pkg;

    localparam int DEPTH_W   = 9;
    localparam int COLOR_W   = 18;
    localparam int COLUMN_W  = 18;
    localparam int ROW_W     = 18;
    localparam int PIX_ROW_W = 9;
    localparam int PIX_COL_W = 10;
    localparam int REC_W     = DEPTH_W + COLOR_W + COLUMN_W + ROW_W;

    typedef struct packed {
        logic [DEPTH_W-1:0]  depth;
        logic [COLOR_W-1:0]  color;
        logic [COLUMN_W-1:0] column;
        logic [ROW_W-1:0]    row;
    } poly_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_EMIT    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/polygon_regfile.sv
// Polygon slot storage: one synchronous write port, one combinational read
// port, synchronous clear on rst. Valid bits exist only when
// POLY_SKIP_INVALID_EN is defined; otherwise every slot reads as valid.
module polygon_regfile
    import pixel_pkg::*;
#(
    parameter int NUM_POLY = 4,
    parameter int IDX_W    = $clog2(NUM_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [REC_W-1:0] wr_rec,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [REC_W-1:0] rd_rec,
    output logic             rd_valid
);

    logic [REC_W-1:0] slot_q [NUM_POLY];
    logic [REC_W-1:0] slot_d [NUM_POLY];

    // Next slot contents: hold, or overwrite the addressed slot
    always_comb begin
        for (int i = 0; i < NUM_POLY; i++) slot_d[i] = slot_q[i];
        if (wr_en) slot_d[wr_idx] = wr_rec;
    end

    // Slot data register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_POLY; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_POLY; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign rd_rec = slot_q[rd_idx];

`ifdef POLY_SKIP_INVALID_EN
    logic [NUM_POLY-1:0] valid_q;
    logic [NUM_POLY-1:0] valid_d;

    // Next valid bits: written together with the slot data
    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = wr_valid;
    end

    // Valid bit register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    assign rd_valid = valid_q[rd_idx];
`else
    logic unused_wr_valid;
    assign unused_wr_valid = wr_valid;
    assign rd_valid        = 1'b1;
`endif

endmodule

// File: rtl/polygon_scheduler.sv
// Frame scan scheduler: for each pixel, CLEAR (1 cycle), COMPARE (one cycle
// per polygon slot), EMIT (1 cycle). All outputs are registered: the output
// comb computes *_d from the next state so each flop shows the state it
// belongs to. With POLY_SKIP_INVALID_EN defined, invalid slots are presented
// as zero with cmp_en low, without changing the cycle count.
module polygon_scheduler
    import pixel_pkg::*;
#(
    parameter int NUM_POLY = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    localparam int IDX_W   = $clog2(NUM_POLY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_valid,
    input  logic [DEPTH_W-1:0]   wr_depth,
    input  logic [COLOR_W-1:0]   wr_color,
    input  logic [COLUMN_W-1:0]  wr_column,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 pixel_clr,
    output logic                 cmp_en,
    output logic                 pixel_done,
    output logic [PIX_ROW_W-1:0] pixel_row,
    output logic [PIX_COL_W-1:0] pixel_col,
    output logic [DEPTH_W-1:0]   polygon_depth,
    output logic [COLOR_W-1:0]   polygon_color,
    output logic [COLUMN_W-1:0]  polygon_column,
    output logic [ROW_W-1:0]     polygon_row
);

    localparam logic [PIX_ROW_W-1:0] LAST_ROW = PIX_ROW_W'(V_ACTIVE - 1);
    localparam logic [PIX_COL_W-1:0] LAST_COL = PIX_COL_W'(H_ACTIVE - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_POLY - 1);

    scan_state_e          state_q, state_d;
    logic [PIX_ROW_W-1:0] row_q, row_d;
    logic [PIX_COL_W-1:0] col_q, col_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 pixel_clr_q, pixel_clr_d;
    logic                 cmp_en_q, cmp_en_d;
    logic                 pixel_done_q, pixel_done_d;
    poly_rec_t            poly_q, poly_d;

    logic                 wr_accept;
    poly_rec_t            wr_rec;
    logic [REC_W-1:0]     rd_rec;
    logic                 rd_valid;
    logic                 last_pixel;

    // Slot writes only land while idle so the frame sees stable contents
    assign wr_accept  = wr_en && (state_q == ST_IDLE);
    assign wr_rec     = '{depth: wr_depth, color: wr_color, column: wr_column, row: wr_row};
    assign last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // Read port follows the index being loaded into the output registers
    polygon_regfile #(
        .NUM_POLY (NUM_POLY),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_accept),
        .wr_idx   (wr_idx),
        .wr_valid (wr_valid),
        .wr_rec   (wr_rec),
        .rd_idx   (idx_d),
        .rd_rec   (rd_rec),
        .rd_valid (rd_valid)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_clr_q  <= 1'b0;
            cmp_en_q     <= 1'b0;
            pixel_done_q <= 1'b0;
            poly_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pixel_clr_q  <= pixel_clr_d;
            cmp_en_q     <= cmp_en_d;
            pixel_done_q <= pixel_done_d;
            poly_q       <= poly_d;
        end
    end

    // Next state, pixel coordinates and slot index
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_COMPARE;
                idx_d   = '0;
            end
            ST_COMPARE: begin
                if (idx_q == LAST_IDX) state_d = ST_EMIT;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_EMIT: begin
                idx_d = '0;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                state_d = last_pixel ? ST_IDLE : ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        pixel_clr_d  = (state_d == ST_CLEAR);
        cmp_en_d     = (state_d == ST_COMPARE) && rd_valid;
        pixel_done_d = (state_d == ST_EMIT);
        frame_done_d = (state_d == ST_EMIT) && last_pixel;
        poly_d       = cmp_en_d ? poly_rec_t'(rd_rec) : '0;
    end

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign pixel_clr      = pixel_clr_q;
    assign cmp_en         = cmp_en_q;
    assign pixel_done     = pixel_done_q;
    assign pixel_row      = row_q;
    assign pixel_col      = col_q;
    assign polygon_depth  = poly_q.depth;
    assign polygon_color  = poly_q.color;
    assign polygon_column = poly_q.column;
    assign polygon_row    = poly_q.row;

endmodule

// File: tb/tb_polygon_scheduler.sv
// Directed-sequence bench for polygon_scheduler (H_ACTIVE=4, V_ACTIVE=2,
// NUM_POLY=4) with randomized slot data. The expected trace of each frame is
// derived from cycle arithmetic: pixel k occupies cycles 6k+1..6k+6 after
// frame_start, with phase 0 = clear, 1..4 = slot 0..3, 5 = emit.
module tb_polygon_scheduler;

    localparam int NP = 4;
    localparam int HA = 4;
    localparam int VA = 2;
    localparam int PERIOD = NP + 2;
    localparam int FRAME  = PERIOD * HA * VA;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic        wr_valid;
    logic [8:0]  wr_depth;
    logic [17:0] wr_color, wr_column, wr_row;
    logic        frame_start;
    logic        busy, frame_done, pixel_clr, cmp_en, pixel_done;
    logic [8:0]  pixel_row;
    logic [9:0]  pixel_col;
    logic [8:0]  polygon_depth;
    logic [17:0] polygon_color, polygon_column, polygon_row;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_t = 0;

    logic [8:0]  m_depth  [NP];
    logic [17:0] m_color  [NP];
    logic [17:0] m_column [NP];
    logic [17:0] m_row    [NP];
    bit          m_valid  [NP];

    always #5 clk = ~clk;

    polygon_scheduler #(.NUM_POLY(NP), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_depth(wr_depth), .wr_color(wr_color), .wr_column(wr_column), .wr_row(wr_row),
        .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .pixel_clr(pixel_clr), .cmp_en(cmp_en), .pixel_done(pixel_done),
        .pixel_row(pixel_row), .pixel_col(pixel_col),
        .polygon_depth(polygon_depth), .polygon_color(polygon_color),
        .polygon_column(polygon_column), .polygon_row(polygon_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d: observed 0x%0h expected 0x%0h", tag, cur_t, obs, exp);
        end
    endtask

    function automatic bit eff_valid(input int s);
`ifdef POLY_SKIP_INVALID_EN
        return m_valid[s];
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            m_depth[i] = '0; m_color[i] = '0; m_column[i] = '0; m_row[i] = '0; m_valid[i] = 1'b0;
        end
    endtask

    // Drive a slot write for one cycle while idle and record it in the model
    task automatic write_slot(input int s, input bit v, input logic [8:0] d,
                              input logic [17:0] c, input logic [17:0] co, input logic [17:0] r);
        wr_en = 1'b1; wr_idx = 2'(s); wr_valid = v;
        wr_depth = d; wr_color = c; wr_column = co; wr_row = r;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_depth[s] = d; m_color[s] = c; m_column[s] = co; m_row[s] = r; m_valid[s] = v;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_clr"}, 32'(pixel_clr), 0);
        chk({tag, "_cmp"}, 32'(cmp_en), 0);
        chk({tag, "_pdone"}, 32'(pixel_done), 0);
        chk({tag, "_fdone"}, 32'(frame_done), 0);
        chk({tag, "_row"}, 32'(pixel_row), 0);
        chk({tag, "_col"}, 32'(pixel_col), 0);
        chk({tag, "_pdepth"}, 32'(polygon_depth), 0);
        chk({tag, "_pcolor"}, 32'(polygon_color), 0);
        chk({tag, "_pcolumn"}, 32'(polygon_column), 0);
        chk({tag, "_prow"}, 32'(polygon_row), 0);
    endtask

    // Pulse frame_start (any write already driven by the caller lands in the
    // same cycle) and check the whole frame cycle by cycle.
    task automatic run_frame(input int abort_at, input bit inject);
        int k, p, s;
        bit e_cmp;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wr_en = 1'b0;
        for (int t = 1; t <= FRAME + 1; t++) begin
            if (t > 1) begin @(posedge clk); #1; end
            cur_t = t;
            if (t <= FRAME) begin
                k = (t - 1) / PERIOD;
                p = (t - 1) % PERIOD;
                s = p - 1;
                e_cmp = (p >= 1 && p <= NP) ? eff_valid(s) : 1'b0;
                chk("busy", 32'(busy), 1);
                chk("pixel_clr", 32'(pixel_clr), 32'(p == 0));
                chk("cmp_en", 32'(cmp_en), 32'(e_cmp));
                chk("pixel_done", 32'(pixel_done), 32'(p == PERIOD - 1));
                chk("frame_done", 32'(frame_done), 32'(t == FRAME));
                chk("pixel_row", 32'(pixel_row), 32'(k / HA));
                chk("pixel_col", 32'(pixel_col), 32'(k % HA));
                chk("poly_depth", 32'(polygon_depth), e_cmp ? 32'(m_depth[s]) : 0);
                chk("poly_color", 32'(polygon_color), e_cmp ? 32'(m_color[s]) : 0);
                chk("poly_column", 32'(polygon_column), e_cmp ? 32'(m_column[s]) : 0);
                chk("poly_row", 32'(polygon_row), e_cmp ? 32'(m_row[s]) : 0);
            end else begin
                chk_idle_zero("post_frame");
            end
            if (inject && t == 2 * PERIOD + 2) begin
                wr_en = 1'b1; wr_idx = 2'd2; wr_valid = 1'b1; wr_depth = 9'h1FF;
                frame_start = 1'b1;
            end
            if (inject && t == 2 * PERIOD + 3) begin
                wr_en = 1'b0; frame_start = 1'b0;
            end
            if (t == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                cur_t = t + 1;
                chk_idle_zero("after_rst");
                model_clear();
                for (int j = 0; j < 2 * PERIOD; j++) begin
                    @(posedge clk); #1;
                    chk("no_fdone_after_rst", 32'(frame_done), 0);
                    chk("idle_after_rst", 32'(busy), 0);
                end
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; wr_depth = '0;
        wr_color = '0; wr_column = '0; wr_row = '0; frame_start = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b0;

        // Slots 0..3 with depth 1..4
        for (int i = 0; i < NP; i++)
            write_slot(i, 1'b1, 9'(i + 1), 18'($urandom), 18'($urandom), 18'($urandom));
        run_frame(0, 1'b0);

        // Fully random slot contents and valid bits
        for (int i = 0; i < NP; i++)
            write_slot(i, 1'($urandom_range(0, 1)), 9'($urandom), 18'($urandom),
                       18'($urandom), 18'($urandom));
        run_frame(0, 1'b0);

        // Mid-frame write to slot 2 and mid-frame frame_start are ignored
        run_frame(0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stay_idle", 32'(busy), 0);
        end

        // Write and frame_start in the same idle cycle
        wr_en = 1'b1; wr_idx = 2'd0; wr_valid = 1'b1; wr_depth = 9'($urandom);
        wr_color = 18'h3FFFF; wr_column = 18'($urandom); wr_row = 18'($urandom);
        m_depth[0] = wr_depth; m_color[0] = wr_color; m_column[0] = wr_column;
        m_row[0] = wr_row; m_valid[0] = 1'b1;
        run_frame(0, 1'b0);

        // Reset in the middle of a frame, then a fresh frame over cleared slots
        for (int i = 0; i < NP; i++)
            write_slot(i, 1'b1, 9'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
        run_frame(20, 1'b0);
        run_frame(0, 1'b0);

        // Only slot 1 marked valid
        for (int i = 0; i < NP; i++)
            write_slot(i, (i == 1), 9'($urandom_range(1, 511)), 18'($urandom_range(1, 262143)),
                       18'($urandom), 18'($urandom));
        run_frame(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
